md_hilo_unit: RTL

- Multiply/divide execution unit with architectural HI/LO registers, sitting in the EX stage beside the ALU.
- Consumes the MD fields of the decoded EX control word: MDFunc, MDSign, MDHIWB, MDLOWB.
- Drives HI/LO to the EX result mux for mfhi/mflo.
- Raises a stall request that the hazard logic ORs into pipeline_stall while an iterative operation is in flight.

---
 rtl/md_hilo_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/md_hilo_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the EX stage.
// Multiplies complete after MUL_LAT cycles; divides use a 32-step restoring divider plus a sign fixup.
module md_hilo_unit #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_func,
   input  logic        md_sign,
   input  logic        hi_rd,
   input  logic        lo_rd,
   input  logic        md_flush,
   input  logic        md_cancel,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        md_stall
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DFIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d;

   logic        func_vld, accept;
   logic [63:0] mul_a, mul_b;
   logic [31:0] abs_a, abs_b;
   logic [32:0] div_sh, div_sub;
   logic [31:0] q_fix, r_fix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         prod_q  <= prod_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   always_comb begin
      func_vld = (md_func != 3'd0) && (md_func <= 3'd4);
      accept   = (state_q == IDLE) && func_vld && !md_flush && !md_cancel;

      // Sign/zero extension to 64 bits lets one truncated multiply serve mult and multu.
      mul_a = {{32{md_sign & src_a[31]}}, src_a};
      mul_b = {{32{md_sign & src_b[31]}}, src_b};
      abs_a = (md_sign && src_a[31]) ? (~src_a + 32'd1) : src_a;
      abs_b = (md_sign && src_b[31]) ? (~src_b + 32'd1) : src_b;

      // Borrow out of the 33-bit subtract means the shifted remainder is below the divisor.
      div_sh  = {rem_q, quo_q[31]};
      div_sub = div_sh - {1'b0, dvs_q};
      q_fix   = qneg_q ? (~quo_q + 32'd1) : quo_q;
      r_fix   = rneg_q ? (~rem_q + 32'd1) : rem_q;

      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      prod_d  = prod_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (md_func)
                  3'd1: hi_d = src_a;
                  3'd2: lo_d = src_a;
                  3'd3: begin
                     prod_d  = mul_a * mul_b;
                     cnt_d   = 5'(MUL_LAT - 1);
                     state_d = MUL;
                  end
                  3'd4: begin
                     if (src_b != '0) begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        qneg_d  = md_sign & (src_a[31] ^ src_b[31]);
                        rneg_d  = md_sign & src_a[31];
                        cnt_d   = 5'd31;
                        state_d = DIV;
                     end
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (md_cancel) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               hi_d    = prod_q[63:32];
               lo_d    = prod_q[31:0];
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         DIV: begin
            if (md_cancel) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               if (!div_sub[32]) begin
                  rem_d = div_sub[31:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = div_sh[31:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
               if (cnt_q == '0) state_d = DFIX;
               else             cnt_d   = cnt_q - 5'd1;
            end
         end
         DFIX: begin
            if (!md_cancel) begin
               lo_d = q_fix;
               hi_d = r_fix;
            end
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q != IDLE);
   assign md_stall = busy & (func_vld | hi_rd | lo_rd);

endmodule
